// File: rtl/arm_pll_pkg.sv
// Shared definitions for the PLL clock-model chain: mode codes, counter states,
// and small helpers for count sanitising and mode decoding.
// Pure package: no logic, no latency, no flow control.
package arm_pll_pkg;

    // Output-counter mode codes; code 3 is reserved and decodes as OFF.
    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_BYPASS = 2'd1;
    localparam logic [1:0] MODE_NORMAL = 2'd2;

    typedef enum logic [2:0] {
        DELAY  = 3'd0,
        HIGH   = 3'd1,
        LOW    = 3'd2,
        OFF    = 3'd3,
        BYPASS = 3'd4
    } state_t;

    // A programmed count of zero behaves exactly like a count of one.
    function automatic int unsigned nz_cnt(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    // State entered when a mode takes effect outside a LOW boundary:
    // NORMAL starts with the initial delay, anything unknown parks in OFF.
    function automatic state_t mode_to_state(input logic [1:0] mode);
        case (mode)
            MODE_NORMAL: return DELAY;
            MODE_BYPASS: return BYPASS;
            default:     return OFF;
        endcase
    endfunction

endpackage

// File: rtl/arm_post_scale_cntr.sv
// Post-scale output counter: divides the VCO-rate clk into cout with
// programmable high/low/initial counts and OFF/BYPASS/NORMAL modes.
// Latency: config applies on the next output-period boundary (next edge in OFF/BYPASS).
// Backpressure: cfg_ready low while one config is pending; holding cfg_valid does not overwrite it.
// Ports: clk/reset (async active-low); cfg_valid/cfg_ready handshake with
// cfg_high/cfg_low/cfg_initial/cfg_mode; cout divided clock; period_start pulse on each NORMAL rise.
module arm_post_scale_cntr
    import arm_pll_pkg::*;
#(
    parameter int         CNT_W       = 8,
    parameter int         RST_HIGH    = 1,
    parameter int         RST_LOW     = 1,
    parameter int         RST_INITIAL = 1,
    parameter logic [1:0] RST_MODE    = 2'd2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_low,
    input  logic [CNT_W-1:0] cfg_initial,
    input  logic [1:0]       cfg_mode,
    output logic             cout,
    output logic             period_start
);

    localparam int CW = CNT_W + 1;

    localparam logic [CNT_W-1:0] RST_HIGH_V = CNT_W'(RST_HIGH);
    localparam logic [CNT_W-1:0] RST_LOW_V  = CNT_W'(RST_LOW);
    localparam logic [CNT_W-1:0] RST_INIT_V = CNT_W'(RST_INITIAL);
    localparam logic [CW-1:0]    CNT_ONE    = CW'(1);

    // Counter state
    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            cout_q, cout_d;
    logic            period_start_q, period_start_d;

    // Active configuration
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [CNT_W-1:0] init_q, init_d;
    logic [1:0]       mode_q, mode_d;

    // Shadow configuration awaiting a period boundary
    logic [CNT_W-1:0] sh_high_q, sh_high_d;
    logic [CNT_W-1:0] sh_low_q, sh_low_d;
    logic [CNT_W-1:0] sh_init_q, sh_init_d;
    logic [1:0]       sh_mode_q, sh_mode_d;
    logic             pending_q, pending_d;

    logic [CW-1:0] lim_high;
    logic [CW-1:0] lim_low;
    logic [CW-1:0] lim_init;
    logic [1:0]    next_mode;
    logic          apply_cfg;
    logic          xfer;

    assign lim_high = CW'(nz_cnt(32'(high_q)));
    assign lim_low  = CW'(nz_cnt(32'(low_q)));
    assign lim_init = CW'(nz_cnt(32'(init_q)));

    // Mode that governs what happens after a boundary: the pending one if any.
    assign next_mode = pending_q ? sh_mode_q : mode_q;

    // Only one config may sit in the shadow; ready comes straight off the flag.
    assign xfer      = cfg_valid && !pending_q;
    assign cfg_ready = ~pending_q;

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        cout_d         = cout_q;
        period_start_d = 1'b0;
        high_d         = high_q;
        low_d          = low_q;
        init_d         = init_q;
        mode_d         = mode_q;
        sh_high_d      = sh_high_q;
        sh_low_d       = sh_low_q;
        sh_init_d      = sh_init_q;
        sh_mode_d      = sh_mode_q;
        pending_d      = pending_q;
        apply_cfg      = 1'b0;

        case (state_q)
            DELAY: begin
                cout_d = 1'b0;
                if (count_q == lim_init) begin
                    state_d        = HIGH;
                    count_d        = CNT_ONE;
                    cout_d         = 1'b1;
                    period_start_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end

            HIGH: begin
                if (count_q == lim_high) begin
                    state_d = LOW;
                    count_d = CNT_ONE;
                    cout_d  = 1'b0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end

            LOW: begin
                if (count_q == lim_low) begin
                    // Period boundary: the only point a running output changes config.
                    apply_cfg = pending_q;
                    count_d   = CNT_ONE;
                    if (next_mode == MODE_NORMAL) begin
                        state_d        = HIGH;
                        cout_d         = 1'b1;
                        period_start_d = 1'b1;
                    end else begin
                        state_d = mode_to_state(next_mode);
                        cout_d  = 1'b0;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end

            OFF, BYPASS: begin
                // No period in progress, so a pending config lands immediately.
                cout_d = 1'b0;
                if (pending_q) begin
                    apply_cfg = 1'b1;
                    state_d   = mode_to_state(sh_mode_q);
                    count_d   = CNT_ONE;
                end
            end

            default: begin
                state_d = OFF;
                count_d = CNT_ONE;
                cout_d  = 1'b0;
            end
        endcase

        if (apply_cfg) begin
            high_d    = sh_high_q;
            low_d     = sh_low_q;
            init_d    = sh_init_q;
            mode_d    = sh_mode_q;
            pending_d = 1'b0;
        end

        // xfer requires !pending_q, so it never collides with apply_cfg.
        if (xfer) begin
            sh_high_d = cfg_high;
            sh_low_d  = cfg_low;
            sh_init_d = cfg_initial;
            sh_mode_d = cfg_mode;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= mode_to_state(RST_MODE);
            count_q        <= CNT_ONE;
            cout_q         <= 1'b0;
            period_start_q <= 1'b0;
            high_q         <= RST_HIGH_V;
            low_q          <= RST_LOW_V;
            init_q         <= RST_INIT_V;
            mode_q         <= RST_MODE;
            sh_high_q      <= RST_HIGH_V;
            sh_low_q       <= RST_LOW_V;
            sh_init_q      <= RST_INIT_V;
            sh_mode_q      <= RST_MODE;
            pending_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            cout_q         <= cout_d;
            period_start_q <= period_start_d;
            high_q         <= high_d;
            low_q          <= low_d;
            init_q         <= init_d;
            mode_q         <= mode_d;
            sh_high_q      <= sh_high_d;
            sh_low_q       <= sh_low_d;
            sh_init_q      <= sh_init_d;
            sh_mode_q      <= sh_mode_d;
            pending_q      <= pending_d;
        end
    end

    // In BYPASS the VCO clock is passed through; the registered path is held low.
    assign cout         = (state_q == BYPASS) ? clk : cout_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_arm_post_scale_cntr.sv
// Scoreboard bench for arm_post_scale_cntr: stimulus pushes the hand-derived
// per-cycle expectation; a monitor samples cout with clk high and low, plus
// period_start and cfg_ready, and compares against the queue head.
module tb_arm_post_scale_cntr;
    import arm_pll_pkg::*;

    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_high;
    logic [CNT_W-1:0] cfg_low;
    logic [CNT_W-1:0] cfg_initial;
    logic [1:0]       cfg_mode;
    logic             cout;
    logic             period_start;

    arm_post_scale_cntr #(
        .CNT_W      (CNT_W),
        .RST_HIGH   (1),
        .RST_LOW    (1),
        .RST_INITIAL(1),
        .RST_MODE   (2'd2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_high    (cfg_high),
        .cfg_low     (cfg_low),
        .cfg_initial (cfg_initial),
        .cfg_mode    (cfg_mode),
        .cout        (cout),
        .period_start(period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic lo;   // cout while clk low
        logic hi;   // cout while clk high
        logic ps;   // period_start
        logic rdy;  // cfg_ready
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic chk(input string nm, input string fld, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s %s got=%0b want=%0b t=%0t", nm, fld, got, want, $time);
        end
    endtask

    // Monitor: one sample pair per clk cycle, compared against the queue head.
    initial begin
        logic  hi_s;
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #2;
            hi_s = cout;
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk(nm, "cout_hi", hi_s, e.hi);
                chk(nm, "cout_lo", cout, e.lo);
                chk(nm, "period_start", period_start, e.ps);
                chk(nm, "cfg_ready", cfg_ready, e.rdy);
            end
        end
    end

    // One call per clk edge: expectation for the outputs that edge produces.
    task automatic cyc(input logic lo, input logic hi, input logic ps, input logic rdy, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        e.lo  = lo;
        e.hi  = hi;
        e.ps  = ps;
        e.rdy = rdy;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // One full NORMAL period starting at the edge that enters HIGH.
    task automatic exp_period(input int h, input int l, input logic rdy, input string nm);
        for (int i = 0; i < h + l; i++) begin
            if (i == 0)     cyc(1'b1, 1'b1, 1'b1, rdy, nm);
            else if (i < h) cyc(1'b1, 1'b1, 1'b0, rdy, nm);
            else            cyc(1'b0, 1'b0, 1'b0, rdy, nm);
            cfg_valid = 1'b0;
        end
    endtask

    task automatic set_cfg(input int h, input int l, input int ini, input logic [1:0] m);
        cfg_high    = CNT_W'(h);
        cfg_low     = CNT_W'(l);
        cfg_initial = CNT_W'(ini);
        cfg_mode    = m;
        cfg_valid   = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b0;
        cfg_valid   = 1'b0;
        cfg_high    = '0;
        cfg_low     = '0;
        cfg_initial = '0;
        cfg_mode    = MODE_OFF;

        // Reset defaults 1/1/1 NORMAL
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "rst0");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "rst1");
        reset = 1'b1;
        repeat (3) exp_period(1, 1, 1'b1, "def11");

        // Park in OFF, then NORMAL 3/2 with initial 4
        set_cfg(3, 2, 4, MODE_OFF);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, "off_xfer");
        cfg_valid = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "off_wait");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "off_apply");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "off_idle");
        set_cfg(3, 2, 4, MODE_NORMAL);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "norm_xfer");
        cfg_valid = 1'b0;
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b1, "delay4");
        exp_period(3, 2, 1'b1, "p32_a");

        // Mid-HIGH config 1/1; valid held with different fields must not re-transfer
        cyc(1'b1, 1'b1, 1'b1, 1'b1, "p32_b");
        set_cfg(1, 1, 0, MODE_NORMAL);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "mid_xfer");
        set_cfg(5, 5, 0, MODE_NORMAL);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "p32_hi3");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "p32_lo1");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "p32_lo2");
        cyc(1'b1, 1'b1, 1'b1, 1'b1, "apply11");
        cfg_valid = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "p11_lo");

        // Transfer on the boundary edge lands one full period later
        set_cfg(2, 3, 0, MODE_NORMAL);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, "bnd_xfer");
        cfg_valid = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "bnd_wait");
        exp_period(2, 3, 1'b1, "p23_a");

        // Zero high/low behave as 1
        set_cfg(0, 0, 0, MODE_NORMAL);
        exp_period(2, 3, 1'b0, "p23_b");
        exp_period(1, 1, 1'b1, "zero_a");
        exp_period(1, 1, 1'b1, "zero_b");

        // BYPASS: cout follows clk
        set_cfg(1, 1, 1, MODE_BYPASS);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, "byp_xfer");
        cfg_valid = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "byp_wait");
        cyc(1'b0, 1'b1, 1'b0, 1'b1, "byp_on");
        cyc(1'b0, 1'b1, 1'b0, 1'b1, "byp_run");

        // OFF from BYPASS
        set_cfg(1, 1, 1, MODE_OFF);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "off2_xfer");
        cfg_valid = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "off2_on");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "off2_run");

        // NORMAL 2/1 with initial 0 (acts as 1)
        set_cfg(2, 1, 0, MODE_NORMAL);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "n21_xfer");
        cfg_valid = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "n21_delay");
        exp_period(2, 1, 1'b1, "p21");

        // Reset mid-HIGH with a pending BYPASS config
        set_cfg(1, 1, 1, MODE_BYPASS);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, "rst_xfer");
        cfg_valid = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 1'b1, "rst_drop");
        #2;
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "rst_hold");
        reset = 1'b1;
        exp_period(1, 1, 1'b1, "post_rst_a");
        exp_period(1, 1, 1'b1, "post_rst_b");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arm_post_scale_cntr.md
Name: arm_post_scale_cntr

Overview:
- Post-scale output counter for the PLL clock-model chain. Consumes the VCO-rate clock that is derived downstream of the arm_n_cntr input divider.
- Produces one divided output clock `cout` with programmable high count, low count, initial delay and mode.
- Reconfigurable at run time through a valid/ready port. New settings take effect only on an output-period boundary, so `cout` never glitches.

Parameters:
- CNT_W, 8: width of the high/low/initial count fields.
- RST_HIGH, 1: high count loaded at reset.
- RST_LOW, 1: low count loaded at reset.
- RST_INITIAL, 1: initial delay loaded at reset.
- RST_MODE, 2'd2: mode loaded at reset (0=OFF, 1=BYPASS, 2=NORMAL; 3 is treated as OFF).

Ports:
- clk  in  1  VCO-rate clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  high when no config is pending.
- cfg_high  in  CNT_W  high-phase length in clk cycles; 0 is treated as 1.
- cfg_low  in  CNT_W  low-phase length in clk cycles; 0 is treated as 1.
- cfg_initial  in  CNT_W  clk edges before the first cout rise; 0 is treated as 1.
- cfg_mode  in  2  OFF / BYPASS / NORMAL.
- cout  out  1  divided output clock.
- period_start  out  1  one-clk pulse coincident with each cout rise in NORMAL mode.

Behaviour:
- Reset asserted (reset=0), asynchronous:
  - active config := RST_* values; pending flag := 0.
  - count := 1; cout := 0; period_start := 0; cfg_ready := 1.
  - state := DELAY if RST_MODE==NORMAL, OFF if OFF, BYPASS if BYPASS.
- States and transitions (each evaluated on a rising clk edge):
  - DELAY: cout=0. If count==initial: go to HIGH, count:=1, cout:=1, period_start:=1. Otherwise count+1. First cout rise lands on the initial-th edge after reset release.
  - HIGH: if count==high: go to LOW, count:=1, cout:=0. Otherwise count+1.
  - LOW (period boundary when count==low):
    - If a config is pending, apply it and clear pending.
    - Resulting mode NORMAL: go to HIGH, count:=1, cout:=1, period_start:=1.
    - Resulting mode OFF or BYPASS: go to that state.
    - If count!=low: count+1.
  - OFF: cout=0.
  - BYPASS: cout = clk (combinational mux; registered cout is held 0).
  - In OFF or BYPASS, a pending config is applied on the next edge. New mode NORMAL: go to DELAY with count:=1, using the new initial.
- Resulting waveform in NORMAL: period = high+low clk cycles, cout high for `high` cycles.
- Config handshake:
  - Transfer occurs on an edge where cfg_valid && cfg_ready. Fields are captured into shadow registers and pending:=1.
  - cfg_ready = ~pending (registered). It stays low until the config is applied.
  - A transfer on the same edge as a LOW boundary is applied at the next boundary, not the current one.
  - The initial field is used only on entry to DELAY; a NORMAL→NORMAL change ignores it.
- Arithmetic: count is CNT_W+1 bits; compares are equality only; no wrap-around beyond the terminal count.
- Reset mid-operation: cout drops to 0 immediately. Any pending config is discarded and RST_* values are reloaded.
- period_start is 0 outside the edge that enters HIGH.

Decomposition:
- Shared package arm_pll_pkg:
  - mode constants MODE_OFF, MODE_BYPASS, MODE_NORMAL.
  - state enum DELAY, HIGH, LOW, OFF, BYPASS.
  - helper function that maps a zero count to 1.
- Single module; no sub-module. The shadow/pending logic is small enough to stay inline.

Test Plan:
- Reset defaults (1/1/1, NORMAL), release reset → cout rises on 1st edge, then toggles every edge; period_start pulses every 2 edges.
- Config high=3, low=2, initial=4, mode NORMAL from OFF → cfg_ready drops 1 cycle. First rise 4 edges after DELAY entry, then a 5-cycle period: 3 high, 2 low.
- Running 3/2, config high=1, low=1 accepted mid-HIGH → current 3/2 period completes, next period 1/1. cfg_ready stays low until that boundary.
- cfg_valid held while pending → no second transfer. Transfer on the boundary edge is applied one full period later.
- Mode BYPASS → cout follows clk on the next edge. Mode OFF → cout=0. Fields of 0 → behave as 1.
- reset asserted while cout=1 mid-HIGH with a config pending → cout=0 immediately. After release, RST_* behaviour resumes and the pending config is lost.
